muldiv: RTL and testbench
=========================

Name: muldiv

Overview:
- Iterative multiply/divide unit in the EX stage of the MIPS pipeline.
- Consumes the two operand words read from the register file (rs on `a`, rt on `b`) and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers, read later by MFHI/MFLO.
- `busy` is the stall source for the hazard logic: any MFHI/MFLO/mult/div issued while `busy` is high must stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk     in   1      rising-edge clock; sole clock domain.
- reset   in   1      synchronous, active-high reset.
- start   in   1      launch operation; sampled only while busy=0.
- op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a       in   WIDTH  rs operand (multiplicand / dividend); also MTHI/MTLO data.
- b       in   WIDTH  rt operand (multiplier / divisor).
- mthi    in   1      write `a` into HI; honoured only when busy=0 and start=0.
- mtlo    in   1      write `a` into LO; honoured only when busy=0 and start=0.
- busy    out  1      operation in progress.
- done    out  1      one-cycle pulse; HI/LO are valid with the result.
- hi      out  WIDTH  HI register (product upper half / remainder).
- lo      out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. An in-flight operation is discarded; no partial result reaches HI/LO.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Latch op.
  - Latch operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - Latch the sign flags.
  - counter=0, go to RUN. busy=1 from edge k.
- RUN: one iteration per edge, edges k+1..k+WIDTH.
  - Multiply: shift-add, one multiplier bit per edge, LSB first.
  - Divide: restoring; shift the remainder:dividend pair left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - After iteration WIDTH-1, go to FIX.
- FIX, edge k+WIDTH+1:
  - Apply sign correction and write hi/lo.
  - done=1 for exactly the following cycle; busy=0 from the same edge; go to IDLE.
- Latency (WIDTH=32): start at edge k, result in hi/lo after edge k+33, busy high for 33 cycles.
- hi/lo hold their previous values throughout RUN; they are updated only in FIX, by mthi/mtlo, or by reset.
- Sign rules for signed ops:
  - Product is negated over the full 2*WIDTH bits if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops apply no correction.
- Divide by zero (DIV and DIVU): lo=all ones, hi=a as latched (original signed value). No exception is raised.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (negation truncated to WIDTH).
- Operand capture: a/b are captured at start; changes to a/b during RUN have no effect.
- Priority when busy=0:
  - start beats mthi/mtlo (writes dropped).
  - mthi and mtlo asserted together write both registers with `a`.
- Ignored inputs while busy=1: start, mthi and mtlo are all ignored. No queuing; the hazard unit guarantees re-issue.
- start on the cycle done=1 is legal: busy=0 then, so the new operation launches with zero bubble.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy=1 for 33 cycles; after edge 33 hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 3*5 launched; at edge 5 assert start (DIVU 9/3) plus mthi a=0x1234 -> both ignored; final hi=0, lo=15. Then mthi a=0x1234 -> hi=0x1234.
- DIVU 100/7 running; at edge 10 assert reset -> next cycle busy=0, done=0, hi=lo=0. Relaunch -> lo=14, hi=2 after 33 cycles.
- Back-to-back: start MULTU 2*3 in the done cycle of a prior op -> prior result visible for one cycle, new result hi=0, lo=6 after 33 more cycles.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit for the EX stage.
//
// Executes MULT, MULTU, DIV and DIVU with one iteration per clock, WIDTH
// iterations per operation. It also holds the architectural HI/LO registers.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards any in-flight operation
//   start      launch an operation (sampled only while busy=0)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b       rs / rt operands; a is also the MTHI/MTLO write data
//   mthi/mtlo  write a into HI/LO (only when busy=0 and start=0)
//   busy       operation in progress; stall source for the hazard unit
//   done       one-cycle pulse when hi/lo hold a new result
//   hi, lo     HI/LO registers
//
// Handshake: start is accepted on any edge where busy=0. busy rises on that
// edge and stays high for WIDTH+1 cycles. On the edge where busy falls, hi/lo
// take the result and done is high for that one cycle. start, mthi and mtlo
// are ignored while busy=1, and nothing is queued. start in the done cycle
// launches the next operation with no bubble.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 neg_res;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        // Operand magnitudes: only signed ops (op[0]=0) take absolute values.
        mag_a      = (a[WIDTH-1] && !op[0]) ? -a : a;
        mag_b      = (b[WIDTH-1] && !op[0]) ? -b : b;

        mul_addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

        // Remainder shifted left with the next dividend bit brought in.
        div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff   = div_shift - {1'b0, opnd_q};

        // The sign flags are only ever set for signed ops.
        neg_res    = sign_a_q ^ sign_b_q;
        prod_fix   = neg_res ? -acc_q : acc_q;
        quo_fix    = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        state_d    = state_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        b_zero_d   = b_zero_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    sign_a_d = a[WIDTH-1] & ~op[0];
                    sign_b_d = b[WIDTH-1] & ~op[0];
                    b_zero_d = (b == {WIDTH{1'b0}});
                    a_raw_d  = a;
                    opnd_d   = op[1] ? mag_b : mag_a;
                    acc_d    = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the difference only if it did not borrow.
                    if (div_diff[WIDTH])
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    // Shift-add step: the carry of the add becomes the new top bit.
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    // Most-negative / -1 falls out naturally: the quotient
                    // negation wraps back to the most-negative value.
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: self-checking bench for muldiv (WIDTH=32).
// Results are predicted with plain 64-bit / 32-bit integer arithmetic.
module tb_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total  = 0;
    int passed = 0;

    muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                up = sp;
                eh = up[63:32];
                el = up[31:0];
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                eh = up[63:32];
                el = up[31:0];
            end
            2'b10: begin
                if (y == 0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    eh = 32'h0;
                    el = 32'h8000_0000;
                end else begin
                    el = sx / sy;
                    eh = sx % sy;
                end
            end
            default: begin
                if (y == 0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return W'($urandom_range(0, 20));
            1:       return 32'd0 - W'($urandom_range(1, 20));
            2:       return 32'h8000_0000;
            3:       return 32'h0;
            4:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Called just after a negedge; start is seen on the next posedge (edge k).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] ph, output logic [W-1:0] pl);
        ph = hi;
        pl = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Counts busy cycles until done, tracking that hi/lo hold ph/pl meanwhile.
    // Returns at the negedge of the done cycle (or after the cycle budget).
    task automatic wait_done(input logic [W-1:0] ph, input logic [W-1:0] pl,
                             output int cycles, output bit held_ok, output bit timed_out);
        cycles  = 0;
        held_ok = 1'b1;
        @(negedge clk);
        while (done !== 1'b1 && cycles < 60) begin
            if (busy !== 1'b1 || hi !== ph || lo !== pl) held_ok = 1'b0;
            cycles++;
            @(negedge clk);
        end
        timed_out = (done !== 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (hi !== '0) $display("FAIL reset_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== '0) $display("FAIL reset_lo: got %h expected 0", lo); else passed++;
    endtask

    task automatic test_directed();
        logic [1:0]   t_op[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
        logic [W-1:0] t_a[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [W-1:0] t_b[5]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] t_hi[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0};
        logic [W-1:0] t_lo[5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] ph, pl;
        int           cycles;
        bit           held_ok, timed_out;
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i], ph, pl);
            total++; if (busy !== 1'b1) $display("FAIL dir%0d_busy_rise: got %b expected 1", i, busy); else passed++;
            wait_done(ph, pl, cycles, held_ok, timed_out);
            total++; if (timed_out || cycles != 33) $display("FAIL dir%0d_latency: got %0d busy cycles expected 33", i, cycles); else passed++;
            total++; if (!held_ok) $display("FAIL dir%0d_hold: got hi/lo/busy disturbed during run expected held", i); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL dir%0d_busy_fall: got %b expected 0", i, busy); else passed++;
            total++; if (hi !== t_hi[i]) $display("FAIL dir%0d_hi: got %h expected %h", i, hi, t_hi[i]); else passed++;
            total++; if (lo !== t_lo[i]) $display("FAIL dir%0d_lo: got %h expected %h", i, lo, t_lo[i]); else passed++;
            @(negedge clk);
            total++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); else passed++;
        end
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] x, y, eh, el, ph, pl;
        int           cycles;
        bit           held_ok, timed_out;
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            model(o, x, y, eh, el);
            issue(o, x, y, ph, pl);
            wait_done(ph, pl, cycles, held_ok, timed_out);
            total++; if (timed_out || cycles != 33 || !held_ok)
                $display("FAIL rnd%0d_timing: got %0d cycles hold=%0b expected 33 cycles hold=1", i, cycles, held_ok);
            else passed++;
            total++; if (hi !== eh || lo !== el)
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, x, y, hi, lo, eh, el);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [W-1:0] ph, pl;
        int           cycles;
        bit           held_ok, timed_out;
        // mthi and mtlo together write both registers.
        mthi = 1'b1; mtlo = 1'b1; a = 32'hA5A5_0001;
        @(posedge clk);
        #1 mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'hA5A5_0001) $display("FAIL mt_both_hi: got %h expected a5a50001", hi); else passed++;
        total++; if (lo !== 32'hA5A5_0001) $display("FAIL mt_both_lo: got %h expected a5a50001", lo); else passed++;
        // start beats mthi/mtlo: the moves are dropped.
        mthi = 1'b1; mtlo = 1'b1;
        issue(2'b01, 32'd3, 32'd4, ph, pl);
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'hA5A5_0001 || lo !== 32'hA5A5_0001)
            $display("FAIL start_beats_mt: got %h_%h expected a5a50001_a5a50001", hi, lo);
        else passed++;
        wait_done(ph, pl, cycles, held_ok, timed_out);
        total++; if (timed_out || hi !== 32'd0 || lo !== 32'd12)
            $display("FAIL start_beats_mt_result: got %h_%h expected 00000000_0000000c", hi, lo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [W-1:0] ph, pl;
        int           cycles;
        bit           held_ok, timed_out;
        issue(2'b01, 32'd3, 32'd5, ph, pl);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'h1234; b = 32'd3; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wait_done(ph, pl, cycles, held_ok, timed_out);
        total++; if (timed_out || cycles != 28 || !held_ok)
            $display("FAIL ignore_timing: got %0d cycles hold=%0b expected 28 cycles hold=1", cycles, held_ok);
        else passed++;
        total++; if (hi !== 32'd0 || lo !== 32'd15)
            $display("FAIL ignore_result: got %h_%h expected 00000000_0000000f", hi, lo);
        else passed++;
        // done cycle: busy=0, so a move is honoured.
        mthi = 1'b1; a = 32'h1234;
        @(posedge clk);
        #1 mthi = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'h1234 || lo !== 32'd15)
            $display("FAIL mthi_after: got %h_%h expected 00001234_0000000f", hi, lo);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ignore_no_queue: got busy %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ph, pl;
        int           cycles;
        bit           held_ok, timed_out, quiet;
        issue(2'b11, 32'd100, 32'd7, ph, pl);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy, done);
        else passed++;
        total++; if (hi !== '0 || lo !== '0)
            $display("FAIL midreset_hilo: got %h_%h expected 0_0", hi, lo);
        else passed++;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) quiet = 1'b0;
        end
        total++; if (!quiet) $display("FAIL midreset_discard: got activity after reset expected none"); else passed++;
        issue(2'b11, 32'd100, 32'd7, ph, pl);
        wait_done(ph, pl, cycles, held_ok, timed_out);
        total++; if (timed_out || cycles != 33 || hi !== 32'd2 || lo !== 32'd14)
            $display("FAIL midreset_relaunch: got %0d cycles %h_%h expected 33 cycles 00000002_0000000e", cycles, hi, lo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ph, pl;
        int           cycles;
        bit           held_ok, timed_out;
        issue(2'b00, 32'hFFFF_FFFB, 32'd6, ph, pl);
        wait_done(ph, pl, cycles, held_ok, timed_out);
        total++; if (timed_out || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFE2)
            $display("FAIL b2b_first: got %h_%h expected ffffffff_ffffffe2", hi, lo);
        else passed++;
        // Launch in the done cycle.
        issue(2'b01, 32'd2, 32'd3, ph, pl);
        total++; if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_launch: got busy=%b done=%b expected 1 0", busy, done);
        else passed++;
        wait_done(ph, pl, cycles, held_ok, timed_out);
        total++; if (timed_out || cycles != 33 || !held_ok)
            $display("FAIL b2b_timing: got %0d cycles hold=%0b expected 33 cycles hold=1", cycles, held_ok);
        else passed++;
        total++; if (hi !== 32'd0 || lo !== 32'd6)
            $display("FAIL b2b_second: got %h_%h expected 00000000_00000006", hi, lo);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_priority();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
